// File: rtl/lb_write_scheduler.sv
// Write-side scheduler for the stencil line-buffer ring: addresses, row occupancy, frame sequencing.
// Optional stall statistics are enabled by defining LB_SCHED_STATS_EN.
module lb_write_scheduler #(
  parameter int LINES     = 4,
  parameter int LINE_BITS = $clog2(LINES),
  parameter int WIDTH     = 1920,
  parameter int AW        = $clog2(WIDTH),
  parameter int HEIGHT    = 1080,
  parameter int HW        = $clog2(HEIGHT + 1),
  parameter int SH        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [LINE_BITS-1:0] wr_line,
  output logic [AW-1:0]        wr_col,
  input  logic                 rd_row_done,
  output logic                 rd_avail,
  output logic [LINE_BITS-1:0] rd_base_line,
  output logic [LINE_BITS:0]   occupancy,
  output logic                 frame_done,
  output logic                 underflow_err,
  output logic [31:0]          stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [LINE_BITS:0]   LP_LINES     = (LINE_BITS+1)'(LINES);
  localparam logic [LINE_BITS:0]   LP_SH        = (LINE_BITS+1)'(SH);
  localparam logic [AW-1:0]        LP_COL_LAST  = AW'(WIDTH - 1);
  localparam logic [LINE_BITS-1:0] LP_LINE_LAST = LINE_BITS'(LINES - 1);
  localparam logic [HW-1:0]        LP_ROW_LAST  = HW'(HEIGHT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AW-1:0]        r_wr_col;
  logic [LINE_BITS-1:0] r_wr_line;
  logic [HW-1:0]        r_rows;
  logic [LINE_BITS:0]   r_occ;
  logic [LINE_BITS-1:0] r_base;
  logic                 r_rd_avail;
  logic                 r_underflow;

  logic w_fill;
  logic w_drain;
  logic w_ready;
  logic w_wr;
  logic w_row_end;
  logic w_ret;
  logic w_start;
  logic w_frame_done;

  assign w_fill    = (r_state == S_FILL);
  assign w_drain   = (r_state == S_DRAIN);
  assign w_ready   = w_fill && (r_occ < LP_LINES);
  assign w_wr      = in_valid && w_ready;
  assign w_row_end = w_wr && (r_wr_col == LP_COL_LAST);
  assign w_ret     = rd_row_done && (r_occ != '0);
  assign w_start   = (r_state == S_IDLE) && frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    unique case (r_state)
      S_IDLE:  if (frame_start) w_state_nxt = S_FILL;
      S_FILL:  if (w_row_end && (r_rows == LP_ROW_LAST)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_occ == '0) w_state_nxt = S_DONE;
      S_DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_col    <= '0;
      r_wr_line   <= '0;
      r_rows      <= '0;
      r_occ       <= '0;
      r_base      <= '0;
      r_rd_avail  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Availability lags occupancy by one cycle by design.
      r_rd_avail <= (w_fill && (r_occ >= LP_SH)) || (w_drain && (r_occ != '0));
      if (w_start) begin
        r_wr_col    <= '0;
        r_wr_line   <= '0;
        r_rows      <= '0;
        r_occ       <= '0;
        r_base      <= '0;
        r_underflow <= 1'b0;
      end else begin
        if (w_wr)
          r_wr_col <= w_row_end ? '0 : r_wr_col + 1'b1;
        if (w_row_end) begin
          r_wr_line <= (r_wr_line == LP_LINE_LAST) ? '0 : r_wr_line + 1'b1;
          r_rows    <= r_rows + 1'b1;
        end
        if (w_row_end && !w_ret)
          r_occ <= r_occ + 1'b1;
        else if (!w_row_end && w_ret)
          r_occ <= r_occ - 1'b1;
        if (w_ret)
          r_base <= (r_base == LP_LINE_LAST) ? '0 : r_base + 1'b1;
        if (rd_row_done && (r_occ == '0))
          r_underflow <= 1'b1;
      end
    end
  end

`ifdef LB_SCHED_STATS_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall <= '0;
    else if (w_start)
      r_stall <= '0;
    else if (w_fill && in_valid && !w_ready && (r_stall != '1))
      r_stall <= r_stall + 1'b1;
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif

  assign in_ready      = w_ready;
  assign wr_en         = w_wr;
  assign wr_line       = r_wr_line;
  assign wr_col        = r_wr_col;
  assign rd_avail      = r_rd_avail;
  assign rd_base_line  = r_base;
  assign occupancy     = r_occ;
  assign frame_done    = w_frame_done;
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_lb_write_scheduler.sv
// Bench for lb_write_scheduler: pixel-count model checked every cycle plus directed literal checks.
// Build with LB_SCHED_STATS_EN defined to exercise the stall counter.
module tb_lb_write_scheduler;

  localparam int LINES  = 4;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 6;
  localparam int SH     = 3;
  localparam int LB     = $clog2(LINES);
  localparam int AW     = $clog2(WIDTH);

`ifdef LB_SCHED_STATS_EN
  localparam int STALL_EXP = 4;
`else
  localparam int STALL_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          in_valid = 1'b0;
  logic          rd_row_done = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [LB-1:0] wr_line;
  logic [AW-1:0] wr_col;
  logic          rd_avail;
  logic [LB-1:0] rd_base_line;
  logic [LB:0]   occupancy;
  logic          frame_done;
  logic          underflow_err;
  logic [31:0]   stall_cycles;

  lb_write_scheduler #(
    .LINES(LINES), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SH(SH)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_line(wr_line), .wr_col(wr_col), .rd_row_done(rd_row_done),
    .rd_avail(rd_avail), .rd_base_line(rd_base_line),
    .occupancy(occupancy), .frame_done(frame_done),
    .underflow_err(underflow_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_done = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 fill, 2 drain, 3 done; addresses derive from pixel count.
  int          m_phase = 0;
  int          m_pix = 0;
  int          m_occ = 0;
  int          m_base = 0;
  bit          m_avail = 0;
  bit          m_uf = 0;
  logic [31:0] m_stall = '0;
  logic        m_rdy, m_acc, m_rend, m_ret;

  assign m_rdy  = (m_phase == 1) && (m_occ < LINES);
  assign m_acc  = m_rdy && in_valid;
  assign m_rend = m_acc && ((m_pix % WIDTH) == WIDTH - 1);
  assign m_ret  = rd_row_done && (m_occ > 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_pix <= 0; m_occ <= 0; m_base <= 0;
      m_avail <= 0; m_uf <= 0; m_stall <= '0;
    end else begin
      m_avail <= ((m_phase == 1) && (m_occ >= SH)) ||
                 ((m_phase == 2) && (m_occ > 0));
      if ((m_phase == 0) && frame_start) begin
        m_phase <= 1; m_pix <= 0; m_occ <= 0; m_base <= 0;
        m_uf <= 0; m_stall <= '0;
      end else begin
        m_pix <= m_pix + int'(m_acc);
        m_occ <= m_occ + int'(m_rend) - int'(m_ret);
        if (m_ret) m_base <= (m_base + 1) % LINES;
        if (rd_row_done && (m_occ == 0)) m_uf <= 1;
        if ((m_phase == 1) && in_valid && !m_rdy && (m_stall != 32'hffff_ffff))
          m_stall <= m_stall + 1;
        case (m_phase)
          1: if (m_pix + int'(m_acc) == WIDTH * HEIGHT) m_phase <= 2;
          2: if (m_occ == 0) m_phase <= 3;
          3: m_phase <= 0;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", in_ready, m_rdy);
      chk("m_wr_en", wr_en, m_acc);
      chk("m_wr_line", wr_line, (m_pix / WIDTH) % LINES);
      chk("m_wr_col", wr_col, m_pix % WIDTH);
      chk("m_rd_avail", rd_avail, m_avail);
      chk("m_rd_base", rd_base_line, m_base);
      chk("m_occ", occupancy, m_occ);
      chk("m_frame_done", frame_done, m_phase == 3);
      chk("m_underflow", underflow_err, m_uf);
`ifdef LB_SCHED_STATS_EN
      chk("m_stall", stall_cycles, m_stall);
`else
      chk("m_stall", stall_cycles, 0);
`endif
    end
    if (wr_en) n_acc++;
    if (frame_done) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int c3, ca;

  initial begin
    repeat (2) step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_col", wr_col, 0);
    chk("rst_stall", stall_cycles, 0);
    step();

    // 1: fill with no reads until the ring is full
    n_acc = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    in_valid = 1'b1;
    c3 = -1;
    ca = -1;
    for (int i = 0; i < 100; i++) begin
      if (occupancy == 3 && c3 < 0) c3 = i;
      if (rd_avail && ca < 0) ca = i;
      if (occupancy == 4) break;
      step();
    end
    chk("full_occ", occupancy, 4);
    chk("full_ready", in_ready, 0);
    chk("full_acc32", n_acc, 32);
    chk("avail_lag", ca - c3, 1);
    repeat (4) step();
    in_valid = 1'b0;
    chk("stall_cnt", stall_cycles, STALL_EXP);

    // 2: one retire frees a line; next row wraps to line 0
    rd_row_done = 1'b1;
    step();
    rd_row_done = 1'b0;
    chk("ret_occ", occupancy, 3);
    chk("ret_base", rd_base_line, 1);
    chk("ret_ready", in_ready, 1);
    in_valid = 1'b1;
    #1;
    chk("wrap_wr_en", wr_en, 1);
    chk("wrap_line", wr_line, 0);

    // 3: retire coincides with row completion
    repeat (7) step();
    chk("row5_col7", wr_col, 7);
    rd_row_done = 1'b1;
    step();
    rd_row_done = 1'b0;
    in_valid = 1'b0;
    chk("simul_occ", occupancy, 3);
    chk("simul_base", rd_base_line, 2);
    chk("simul_line", wr_line, 1);

    // 4: last row, then drain to frame_done
    in_valid = 1'b1;
    rd_row_done = 1'b1;
    step();
    rd_row_done = 1'b0;
    repeat (7) step();
    chk("drain_ready", in_ready, 0);
    chk("drain_occ", occupancy, 3);
    chk("drain_acc48", n_acc, 48);
    repeat (2) step();
    in_valid = 1'b0;
    chk("drain_avail", rd_avail, 1);
    for (int k = 0; k < 3; k++) begin
      rd_row_done = 1'b1;
      step();
      rd_row_done = 1'b0;
      repeat (2) step();
    end
    for (int i = 0; i < 20; i++) begin
      if (n_done > 0) break;
      step();
    end
    repeat (3) step();
    chk("done_once", n_done, 1);
    chk("done_acc", n_acc, 48);
    chk("idle_ready", in_ready, 0);
    chk("idle_occ", occupancy, 0);
    chk("idle_stall", stall_cycles, STALL_EXP);

    // 5: underflow is sticky until the next frame_start
    rd_row_done = 1'b1;
    step();
    rd_row_done = 1'b0;
    chk("uf_set", underflow_err, 1);
    chk("uf_occ", occupancy, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("uf_clear", underflow_err, 0);
    chk("start_stall", stall_cycles, 0);

    // 6: asynchronous reset mid-row
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (wr_col == 5) break;
      step();
    end
    chk("mid_col", wr_col, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_col", wr_col, 0);
    chk("arst_line", wr_line, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_avail", rd_avail, 0);
    chk("arst_stall", stall_cycles, 0);
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("arst_no_done", n_done, 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("restart_wr_en", wr_en, 1);
    chk("restart_line", wr_line, 0);
    chk("restart_col", wr_col, 0);
    repeat (3) step();
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
